// File: rtl/mem_wb_if.sv
// Data-memory request/acknowledge bus between the mem/wb stage and memory.
// The stage is the master: it drives the request and address/data,
// memory answers with a one-cycle ack and load data.
interface mem_wb_if #(
    parameter int DATA_W = 16
) ();
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck;
    logic [DATA_W-1:0] memRData;

    modport master (
        output memReq,
        output memWe,
        output memAddr,
        output memWData,
        input  memAck,
        input  memRData
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memAddr,
        input  memWData,
        output memAck,
        output memRData
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory / writeback pipeline stage.
// ALU results write back one cycle after they are sampled. Loads and stores
// go out on the req/ack bus; while an access is outstanding the stage stalls
// upstream. An access that sees no ack for TIMEOUT_CYC cycles is aborted and
// flags a sticky error. All bus and writeback outputs are registered.
module mem_wb_stage #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemToRegE,
    input  logic [DATA_W-1:0] aluResultE,
    input  logic [DATA_W-1:0] storeDataE,
    input  logic [REG_AW-1:0] destAddE,
    output logic              stallM,
    mem_wb_if.master          mem,
    output logic              RegWriteW,
    output logic [REG_AW-1:0] destAddW,
    output logic [DATA_W-1:0] regWDataW,
    output logic              memErr
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Last counter value before an unacknowledged access is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t              state_r,     state_s;
    logic [7:0]          cnt_r,       cnt_s;
    logic                lat_rw_r,    lat_rw_s;
    logic                lat_mtr_r,   lat_mtr_s;
    logic [REG_AW-1:0]   lat_dest_r,  lat_dest_s;
    logic                mem_req_r,   mem_req_s;
    logic                mem_we_r,    mem_we_s;
    logic [DATA_W-1:0]   mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                reg_write_r, reg_write_s;
    logic [REG_AW-1:0]   dest_r,      dest_s;
    logic [DATA_W-1:0]   wdata_r,     wdata_s;
    logic                err_r,       err_s;

    // Next-state and next-output logic for the IDLE/ACCESS controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        lat_rw_s    = lat_rw_r;
        lat_mtr_s   = lat_mtr_r;
        lat_dest_s  = lat_dest_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        reg_write_s = 1'b0;
        dest_s      = dest_r;
        wdata_s     = wdata_r;
        err_s       = err_r;

        case (state_r)
            IDLE: begin
                if (MemWriteE || MemToRegE) begin
                    // Remember what the load needs for its deferred writeback.
                    lat_rw_s    = RegWriteE;
                    lat_mtr_s   = MemToRegE;
                    lat_dest_s  = destAddE;
                    mem_req_s   = 1'b1;
                    mem_we_s    = MemWriteE;
                    mem_addr_s  = aluResultE;
                    mem_wdata_s = storeDataE;
                    cnt_s       = 8'd0;
                    state_s     = ACCESS;
                end else begin
                    reg_write_s = RegWriteE;
                    dest_s      = destAddE;
                    wdata_s     = aluResultE;
                end
            end
            ACCESS: begin
                if (mem.memAck) begin
                    // Ack wins over a coincident timeout.
                    mem_req_s = 1'b0;
                    state_s   = IDLE;
                    if (lat_mtr_r && !mem_we_r) begin
                        reg_write_s = lat_rw_r;
                        dest_s      = lat_dest_r;
                        wdata_s     = mem.memRData;
                    end else begin
                        reg_write_s = 1'b0;
                    end
                end else if (cnt_r == TMO_LAST) begin
                    mem_req_s = 1'b0;
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                mem_req_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State, bus and writeback registers; reset abandons any access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            lat_rw_r    <= 1'b0;
            lat_mtr_r   <= 1'b0;
            lat_dest_r  <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            reg_write_r <= 1'b0;
            dest_r      <= '0;
            wdata_r     <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            lat_rw_r    <= lat_rw_s;
            lat_mtr_r   <= lat_mtr_s;
            lat_dest_r  <= lat_dest_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            reg_write_r <= reg_write_s;
            dest_r      <= dest_s;
            wdata_r     <= wdata_s;
            err_r       <= err_s;
        end
    end

    assign stallM       = (state_r == ACCESS);
    assign mem.memReq   = mem_req_r;
    assign mem.memWe    = mem_we_r;
    assign mem.memAddr  = mem_addr_r;
    assign mem.memWData = mem_wdata_r;
    assign RegWriteW    = reg_write_r;
    assign destAddW     = dest_r;
    assign regWDataW    = wdata_r;
    assign memErr       = err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a table of directed operations, a few
// hand-written corner sequences, then random operations whose expected results
// come from a transaction-level model of the stage.
module tb_mem_wb_stage;
    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int T      = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWriteE, MemWriteE, MemToRegE;
    logic [DATA_W-1:0] aluResultE, storeDataE;
    logic [REG_AW-1:0] destAddE;
    logic              stallM, RegWriteW, memErr;
    logic [REG_AW-1:0] destAddW;
    logic [DATA_W-1:0] regWDataW;

    mem_wb_if #(.DATA_W(DATA_W)) mem ();

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
        .aluResultE(aluResultE), .storeDataE(storeDataE), .destAddE(destAddE),
        .stallM(stallM), .mem(mem),
        .RegWriteW(RegWriteW), .destAddW(destAddW), .regWDataW(regWDataW),
        .memErr(memErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rw, mw, mtr;
        logic [DATA_W-1:0] alu, sd;
        logic [REG_AW-1:0] dest;
        int                ack_at;   // ACCESS cycle carrying the ack, 0 = never
        logic [DATA_W-1:0] rdata;
        logic              e_rw;
        logic [REG_AW-1:0] e_dest;
        logic [DATA_W-1:0] e_wd;
        logic              e_err;
        int                e_cyc;    // expected cycles with memReq/stallM high
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one operation in IDLE, act as memory, then check the writeback.
    task automatic run_op(input vec_t v);
        RegWriteE  = v.rw;  MemWriteE  = v.mw;  MemToRegE = v.mtr;
        aluResultE = v.alu; storeDataE = v.sd;  destAddE  = v.dest;
        mem.memAck = 1'b0;  mem.memRData = 16'($urandom);
        @(posedge clk); #1;
        for (int k = 1; k <= v.e_cyc; k++) begin
            chk("stall_access", 32'(stallM), 32'd1);
            chk("req_access", 32'(mem.memReq), 32'd1);
            chk("we_access", 32'(mem.memWe), 32'(v.mw));
            chk("addr_access", 32'(mem.memAddr), 32'(v.alu));
            chk("wdata_access", 32'(mem.memWData), 32'(v.sd));
            chk("rw_access", 32'(RegWriteW), 32'd0);
            mem.memAck   = (k == v.ack_at);
            mem.memRData = (k == v.ack_at) ? v.rdata : 16'($urandom);
            // Upstream contents during ACCESS must not matter.
            RegWriteE  = 1'($urandom); MemWriteE = 1'($urandom); MemToRegE = 1'($urandom);
            aluResultE = 16'($urandom); storeDataE = 16'($urandom); destAddE = 4'($urandom);
            @(posedge clk); #1;
            mem.memAck = 1'b0;
        end
        chk("stall_done", 32'(stallM), 32'd0);
        chk("req_done", 32'(mem.memReq), 32'd0);
        chk("regwrite", 32'(RegWriteW), 32'(v.e_rw));
        if (v.e_rw || !(v.mw || v.mtr)) begin
            chk("dest", 32'(destAddW), 32'(v.e_dest));
            chk("wdata", 32'(regWDataW), 32'(v.e_wd));
        end else begin
            chk("wdata_hold", 32'(RegWriteW), 32'd0);
        end
        chk("err", 32'(memErr), 32'(v.e_err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stallM), 32'd0);
        chk({tag, "_req"}, 32'(mem.memReq), 32'd0);
        chk({tag, "_we"}, 32'(mem.memWe), 32'd0);
        chk({tag, "_addr"}, 32'(mem.memAddr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem.memWData), 32'd0);
        chk({tag, "_rw"}, 32'(RegWriteW), 32'd0);
        chk({tag, "_dest"}, 32'(destAddW), 32'd0);
        chk({tag, "_wd"}, 32'(regWDataW), 32'd0);
        chk({tag, "_err"}, 32'(memErr), 32'd0);
    endtask

    vec_t tbl[8];
    vec_t v;
    logic err_m;
    logic is_mem, acked;

    initial begin
        //        rw    mw    mtr   alu       sd        dest  ack rdata     e_rw  e_dest e_wd      e_err cyc
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'h5, 0, 16'h0000, 1'b1, 4'h5, 16'h1234, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 4'h3, 4, 16'hBEEF, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 4'h0, 1, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h1111, 4'h7, 2, 16'h9999, 1'b0, 4'h0, 16'h0000, 1'b0, 2};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000, 4'h9, 0, 16'h0000, 1'b0, 4'h9, 16'h5555, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h0080, 16'h0000, 4'h2, 0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0000, 4'hA, 0, 16'h0000, 1'b1, 4'hA, 16'hABCD, 1'b1, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 16'h0044, 16'h0000, 4'h4, 2, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b1, 2};

        reset = 1'b1;
        RegWriteE = 1'b0; MemWriteE = 1'b0; MemToRegE = 1'b0;
        aluResultE = 16'h0000; storeDataE = 16'h0000; destAddE = 4'h0;
        mem.memAck = 1'b0; mem.memRData = 16'h0000;
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // memAck while IDLE must not disturb an ALU writeback.
        RegWriteE = 1'b1; MemWriteE = 1'b0; MemToRegE = 1'b0;
        aluResultE = 16'h0F0F; destAddE = 4'h1;
        mem.memAck = 1'b1; mem.memRData = 16'hDEAD;
        @(posedge clk); #1;
        mem.memAck = 1'b0;
        chk("idle_ack_stall", 32'(stallM), 32'd0);
        chk("idle_ack_req", 32'(mem.memReq), 32'd0);
        chk("idle_ack_rw", 32'(RegWriteW), 32'd1);
        chk("idle_ack_wd", 32'(regWDataW), 32'h0F0F);

        // Reset in the middle of an outstanding load.
        RegWriteE = 1'b1; MemWriteE = 1'b0; MemToRegE = 1'b1;
        aluResultE = 16'h0300; destAddE = 4'h6;
        @(posedge clk); #1;
        chk("pre_reset_req", 32'(mem.memReq), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        MemToRegE = 1'b0; RegWriteE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_op('{1'b1, 1'b0, 1'b0, 16'h2468, 16'h0000, 4'hC, 0, 16'h0000,
                 1'b1, 4'hC, 16'h2468, 1'b0, 0});

        // Random operations against a transaction-level model.
        err_m = 1'b0;
        for (int n = 0; n < 150; n++) begin
            v.rw     = 1'($urandom);
            v.mw     = ($urandom_range(0, 2) == 0);
            v.mtr    = ($urandom_range(0, 1) == 0);
            v.alu    = 16'($urandom);
            v.sd     = 16'($urandom);
            v.dest   = 4'($urandom);
            v.ack_at = $urandom_range(0, T + 1);
            v.rdata  = 16'($urandom);
            is_mem   = v.mw || v.mtr;
            acked    = (v.ack_at >= 1) && (v.ack_at <= T);
            v.e_cyc  = !is_mem ? 0 : (acked ? v.ack_at : T);
            v.e_rw   = !is_mem ? v.rw : ((acked && v.mtr && !v.mw) ? v.rw : 1'b0);
            v.e_dest = v.dest;
            v.e_wd   = is_mem ? v.rdata : v.alu;
            if (is_mem && !acked) err_m = 1'b1;
            v.e_err  = err_m;
            run_op(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
